// File: rtl/fx2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_pkg
//  Description : Shared constants for the FX2LP slave-FIFO scheduler.
//                Contents: one-hot state encoding, channel indices, FX2
//                endpoint addresses, grant encoding and small channel helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fx2_pkg;

  // One-hot scheduler states. SAMPLE is the final strobe-low cycle, in which
  // a read captures the bus.
  localparam int STATE_W = 6;
  localparam logic [STATE_W-1:0] ST_IDLE    = 6'b000001;
  localparam logic [STATE_W-1:0] ST_TURN    = 6'b000010;
  localparam logic [STATE_W-1:0] ST_ADDR    = 6'b000100;
  localparam logic [STATE_W-1:0] ST_STROBE  = 6'b001000;
  localparam logic [STATE_W-1:0] ST_SAMPLE  = 6'b010000;
  localparam logic [STATE_W-1:0] ST_RELEASE = 6'b100000;

  // Channel indices, also used as request bit positions for the arbiter.
  localparam logic [1:0] CH_EP2 = 2'd0;
  localparam logic [1:0] CH_EP4 = 2'd1;
  localparam logic [1:0] CH_EP6 = 2'd2;

  // FX2 FIFOADDR values.
  localparam logic [1:0] FIFOADDR_EP2 = 2'b00;
  localparam logic [1:0] FIFOADDR_EP4 = 2'b01;
  localparam logic [1:0] FIFOADDR_EP6 = 2'b10;

  // Encoding of the grant output.
  localparam logic [1:0] GRANT_NONE = 2'd0;
  localparam logic [1:0] GRANT_EP2  = 2'd1;
  localparam logic [1:0] GRANT_EP4  = 2'd2;
  localparam logic [1:0] GRANT_EP6  = 2'd3;

  function automatic logic [1:0] ch_fifoaddr(input logic [1:0] ch);
    case (ch)
      CH_EP2:  return FIFOADDR_EP2;
      CH_EP4:  return FIFOADDR_EP4;
      default: return FIFOADDR_EP6;
    endcase
  endfunction

  function automatic logic [1:0] ch_grant(input logic [1:0] ch);
    case (ch)
      CH_EP2:  return GRANT_EP2;
      CH_EP4:  return GRANT_EP4;
      default: return GRANT_EP6;
    endcase
  endfunction

  // Next channel in round-robin order: EP2 -> EP4 -> EP6 -> EP2.
  function automatic logic [1:0] ch_next(input logic [1:0] ch);
    return (ch == CH_EP6) ? CH_EP2 : ch + 2'd1;
  endfunction

  function automatic logic ch_is_write(input logic [1:0] ch);
    return ch == CH_EP6;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fx2_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_rr_arbiter
//  Description : Three-request round-robin arbiter. The search starts at the
//                pointer; when advance is high the pointer moves to the
//                channel after the one currently granted.
//  Ports       : clk, reset_n (async, active-low)
//                req[2:0]   request per channel index
//                advance    commit the current grant and rotate the pointer
//                gnt_valid  some request is present
//                gnt_ch     selected channel index
//  Revision    : 1.0 - initial release
// ============================================================================
module fx2_rr_arbiter
  import fx2_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic [1:0] gnt_ch
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] c0, c1, c2;

  always_comb begin
    c0        = ptr_q;
    c1        = ch_next(c0);
    c2        = ch_next(c1);
    gnt_valid = 1'b1;
    if (req[c0])      gnt_ch = c0;
    else if (req[c1]) gnt_ch = c1;
    else if (req[c2]) gnt_ch = c2;
    else begin
      gnt_ch    = c0;
      gnt_valid = 1'b0;
    end
    ptr_d = (advance && gnt_valid) ? ch_next(gnt_ch) : ptr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= CH_EP2;
    else          ptr_q <= ptr_d;
  end

endmodule
`default_nettype wire

// File: rtl/fx2_fifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_fifo_sched
//  Description : Scheduler/arbiter for the FX2LP asynchronous slave-FIFO bus.
//                Shares usb_fd among EP2 read, EP4 read and EP6 write with
//                round-robin grants, bounded bursts and full strobe timing.
//  Ports       : clk, reset_n (async, active-low), en
//                usb_flaga/b/c  FX2 flags (async): EP2/EP4 not empty, EP6 not full
//                usb_slcs/slrd/slwr/sloe, usb_fifoaddr  FX2 controls
//                usb_fd_i/usb_fd_o/usb_fd_oe  bus sample, drive, tri-state enable
//                rx2/rx4_ready, rx_data, rx2/rx4_valid  read streams
//                tx_data, tx_valid, tx_ready  write stream
//                busy, grant, cnt2/cnt4/cnt6  status
//  Revision    : 1.0 - initial release
// ============================================================================
module fx2_fifo_sched
  import fx2_pkg::*;
#(
  parameter int SETUP     = 2,
  parameter int STROBE    = 4,
  parameter int HOLD      = 4,
  parameter int TURN      = 2,
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             usb_flaga,
  input  logic             usb_flagb,
  input  logic             usb_flagc,
  output logic             usb_slcs,
  output logic             usb_slrd,
  output logic             usb_slwr,
  output logic             usb_sloe,
  output logic [1:0]       usb_fifoaddr,
  input  logic [15:0]      usb_fd_i,
  output logic [15:0]      usb_fd_o,
  output logic             usb_fd_oe,
  input  logic             rx2_ready,
  input  logic             rx4_ready,
  output logic [15:0]      rx_data,
  output logic             rx2_valid,
  output logic             rx4_valid,
  input  logic [15:0]      tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             busy,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt4,
  output logic [CNT_W-1:0] cnt6
);

  localparam int TMR_W   = 8;
  localparam int BURST_W = $clog2(BURST_MAX + 1);
  // With a one-cycle strobe the whole strobe is the sampling cycle.
  localparam logic [STATE_W-1:0] ST_FIRST_STRB = (STROBE > 1) ? ST_STROBE : ST_SAMPLE;

  logic [2:0]         flag_meta_q, flag_meta_d, flag_sync_q, flag_sync_d;
  logic [2:0]         eligible;
  logic               arb_valid, arb_advance;
  logic [1:0]         arb_ch;

  logic [STATE_W-1:0] state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [1:0]         ch_q, ch_d;
  logic               last_wr_q, last_wr_d;
  logic               slrd_q, slrd_d, slwr_q, slwr_d, sloe_q, sloe_d;
  logic               fd_oe_q, fd_oe_d, busy_q, busy_d;
  logic [1:0]         fifoaddr_q, fifoaddr_d, grant_q, grant_d;
  logic [15:0]        fd_o_q, fd_o_d, rx_data_q, rx_data_d;
  logic               rx2_valid_q, rx2_valid_d, rx4_valid_q, rx4_valid_d;
  logic               tx_ready_q, tx_ready_d;
  logic [CNT_W-1:0]   cnt2_q, cnt2_d, cnt4_q, cnt4_d, cnt6_q, cnt6_d;
  logic               wr_d, active_d, strobe_d;

  always_comb begin
    flag_meta_d = {usb_flagc, usb_flagb, usb_flaga};
    flag_sync_d = flag_meta_q;
  end

  assign eligible = flag_sync_q & {tx_valid, rx4_ready, rx2_ready};

  fx2_rr_arbiter u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible),
    .advance   (arb_advance),
    .gnt_valid (arb_valid),
    .gnt_ch    (arb_ch)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q + 1'b1;
    burst_d     = burst_q;
    ch_d        = ch_q;
    last_wr_d   = last_wr_q;
    fd_o_d      = fd_o_q;
    rx_data_d   = rx_data_q;
    rx2_valid_d = 1'b0;
    rx4_valid_d = 1'b0;
    tx_ready_d  = 1'b0;
    cnt2_d      = cnt2_q;
    cnt4_d      = cnt4_q;
    cnt6_d      = cnt6_q;
    arb_advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (en && arb_valid) begin
          arb_advance = 1'b1;
          ch_d        = arb_ch;
          burst_d     = '0;
          last_wr_d   = ch_is_write(arb_ch);
          state_d     = (ch_is_write(arb_ch) != last_wr_q) ? ST_TURN : ST_ADDR;
        end
      end
      ST_TURN: begin
        if (timer_q == TMR_W'(TURN - 1)) begin
          state_d = ST_ADDR;
          timer_d = '0;
        end
      end
      ST_ADDR: begin
        if (timer_q == TMR_W'(SETUP - 1)) begin
          state_d = ST_FIRST_STRB;
          timer_d = '0;
        end
      end
      ST_STROBE: begin
        if (timer_q == TMR_W'(STROBE - 2)) begin
          state_d = ST_SAMPLE;
          timer_d = '0;
        end
      end
      ST_SAMPLE: begin
        // Word is committed here; its pulse and count appear in RELEASE.
        state_d = ST_RELEASE;
        timer_d = '0;
        burst_d = burst_q + 1'b1;
        if (!ch_is_write(ch_q)) rx_data_d = usb_fd_i;
        case (ch_q)
          CH_EP2: begin
            rx2_valid_d = 1'b1;
            cnt2_d      = cnt2_q + 1'b1;
          end
          CH_EP4: begin
            rx4_valid_d = 1'b1;
            cnt4_d      = cnt4_q + 1'b1;
          end
          default: begin
            tx_ready_d = 1'b1;
            cnt6_d     = cnt6_q + 1'b1;
          end
        endcase
      end
      ST_RELEASE: begin
        if (timer_q == TMR_W'(HOLD - 1)) begin
          timer_d = '0;
          if (en && eligible[ch_q] && (burst_q < BURST_W'(BURST_MAX))) state_d = ST_FIRST_STRB;
          else                                                         state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Pin controls are registered from the next state so they switch cleanly
    // on the same edge as the state register.
    wr_d       = ch_is_write(ch_d);
    active_d   = (state_d != ST_IDLE) && (state_d != ST_TURN);
    strobe_d   = (state_d == ST_STROBE) || (state_d == ST_SAMPLE);
    slrd_d     = !(strobe_d && !wr_d);
    slwr_d     = !(strobe_d && wr_d);
    sloe_d     = !(active_d && !wr_d);
    fd_oe_d    = active_d && wr_d;
    fifoaddr_d = active_d ? ch_fifoaddr(ch_d) : fifoaddr_q;
    busy_d     = (state_d != ST_IDLE);
    grant_d    = (state_d == ST_IDLE) ? GRANT_NONE : ch_grant(ch_d);

    // Write data loads on ADDR entry, and again from the second RELEASE cycle
    // on, after the source has seen tx_ready and presented its next word.
    if (wr_d && (((state_d == ST_ADDR) && (state_q != ST_ADDR)) ||
                 ((state_q == ST_RELEASE) && (timer_q != '0))))
      fd_o_d = tx_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag_meta_q <= '0;
      flag_sync_q <= '0;
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      burst_q     <= '0;
      ch_q        <= CH_EP2;
      last_wr_q   <= 1'b0;
      slrd_q      <= 1'b1;
      slwr_q      <= 1'b1;
      sloe_q      <= 1'b1;
      fd_oe_q     <= 1'b0;
      fifoaddr_q  <= FIFOADDR_EP2;
      fd_o_q      <= '0;
      rx_data_q   <= '0;
      rx2_valid_q <= 1'b0;
      rx4_valid_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= GRANT_NONE;
      cnt2_q      <= '0;
      cnt4_q      <= '0;
      cnt6_q      <= '0;
    end else begin
      flag_meta_q <= flag_meta_d;
      flag_sync_q <= flag_sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      burst_q     <= burst_d;
      ch_q        <= ch_d;
      last_wr_q   <= last_wr_d;
      slrd_q      <= slrd_d;
      slwr_q      <= slwr_d;
      sloe_q      <= sloe_d;
      fd_oe_q     <= fd_oe_d;
      fifoaddr_q  <= fifoaddr_d;
      fd_o_q      <= fd_o_d;
      rx_data_q   <= rx_data_d;
      rx2_valid_q <= rx2_valid_d;
      rx4_valid_q <= rx4_valid_d;
      tx_ready_q  <= tx_ready_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
      cnt2_q      <= cnt2_d;
      cnt4_q      <= cnt4_d;
      cnt6_q      <= cnt6_d;
    end
  end

  assign usb_slcs     = 1'b0;
  assign usb_slrd     = slrd_q;
  assign usb_slwr     = slwr_q;
  assign usb_sloe     = sloe_q;
  assign usb_fifoaddr = fifoaddr_q;
  assign usb_fd_o     = fd_o_q;
  assign usb_fd_oe    = fd_oe_q;
  assign rx_data      = rx_data_q;
  assign rx2_valid    = rx2_valid_q;
  assign rx4_valid    = rx4_valid_q;
  assign tx_ready     = tx_ready_q;
  assign busy         = busy_q;
  assign grant        = grant_q;
  assign cnt2         = cnt2_q;
  assign cnt4         = cnt4_q;
  assign cnt6         = cnt6_q;

endmodule
`default_nettype wire

// File: tb/tb_fx2_fifo_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx2_fifo_sched
//  Description : Directed self-checking bench. Instance A uses default
//                parameters; instance B uses BURST_MAX=2, CNT_W=4. Both share
//                the stimulus inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx2_fifo_sched;

  logic        clk, reset_n, en;
  logic        flaga, flagb, flagc;
  logic [15:0] fd_i, tx_data;
  logic        rx2_ready, rx4_ready, tx_valid;

  logic        slcs_a, slrd_a, slwr_a, sloe_a, fd_oe_a, rx2_valid_a, rx4_valid_a, tx_ready_a, busy_a;
  logic [1:0]  fifoaddr_a, grant_a;
  logic [15:0] fd_o_a, rx_data_a, cnt2_a, cnt4_a, cnt6_a;

  logic        slcs_b, slrd_b, slwr_b, sloe_b, fd_oe_b, rx2_valid_b, rx4_valid_b, tx_ready_b, busy_b;
  logic [1:0]  fifoaddr_b, grant_b;
  logic [15:0] fd_o_b, rx_data_b;
  logic [3:0]  cnt2_b, cnt4_b, cnt6_b;

  int errors = 0;
  int checks = 0;

  // Test 2 bookkeeping and expectations.
  logic [1:0] exp_words [8] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1};
  int         exp_gaps  [4] = '{2, 2, 4, 4};
  logic [1:0] obs_words [8];
  int         obs_gaps  [4];
  int         nwords, ngaps, gap, viol, pulses, bad;
  logic       gap_run;
  logic [1:0] prev_g;

  fx2_fifo_sched u_dut_a (
    .clk(clk), .reset_n(reset_n), .en(en),
    .usb_flaga(flaga), .usb_flagb(flagb), .usb_flagc(flagc),
    .usb_slcs(slcs_a), .usb_slrd(slrd_a), .usb_slwr(slwr_a), .usb_sloe(sloe_a),
    .usb_fifoaddr(fifoaddr_a), .usb_fd_i(fd_i), .usb_fd_o(fd_o_a), .usb_fd_oe(fd_oe_a),
    .rx2_ready(rx2_ready), .rx4_ready(rx4_ready), .rx_data(rx_data_a),
    .rx2_valid(rx2_valid_a), .rx4_valid(rx4_valid_a),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_a),
    .busy(busy_a), .grant(grant_a), .cnt2(cnt2_a), .cnt4(cnt4_a), .cnt6(cnt6_a)
  );

  fx2_fifo_sched #(.BURST_MAX(2), .CNT_W(4)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .en(en),
    .usb_flaga(flaga), .usb_flagb(flagb), .usb_flagc(flagc),
    .usb_slcs(slcs_b), .usb_slrd(slrd_b), .usb_slwr(slwr_b), .usb_sloe(sloe_b),
    .usb_fifoaddr(fifoaddr_b), .usb_fd_i(fd_i), .usb_fd_o(fd_o_b), .usb_fd_oe(fd_oe_b),
    .rx2_ready(rx2_ready), .rx4_ready(rx4_ready), .rx_data(rx_data_b),
    .rx2_valid(rx2_valid_b), .rx4_valid(rx4_valid_b),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready_b),
    .busy(busy_b), .grant(grant_b), .cnt2(cnt2_b), .cnt4(cnt4_b), .cnt6(cnt6_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; en = 1'b1;
    flaga = 1'b0; flagb = 1'b0; flagc = 1'b0;
    rx2_ready = 1'b0; rx4_ready = 1'b0; tx_valid = 1'b0;
    tx_data = 16'h0; fd_i = 16'h0;
    tick(3);
    reset_n = 1'b1;
  endtask

  // In the directed tests inputs change 1 unit after edge E0; the design sees
  // them synchronized in the cycle after E2, so design cycle k is k+2 edges on.
  initial begin
    // ---------------- reset values ----------------
    reset_n = 1'b0; en = 1'b1;
    flaga = 1'b0; flagb = 1'b0; flagc = 1'b0;
    rx2_ready = 1'b0; rx4_ready = 1'b0; tx_valid = 1'b0;
    tx_data = 16'h0; fd_i = 16'h0;
    tick(2);
    check("rst_slcs", slcs_a, 0);
    check("rst_slrd", slrd_a, 1);
    check("rst_slwr", slwr_a, 1);
    check("rst_sloe", sloe_a, 1);
    check("rst_fifoaddr", fifoaddr_a, 0);
    check("rst_fd_oe", fd_oe_a, 0);
    check("rst_fd_o", fd_o_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_strobes", {rx2_valid_a, rx4_valid_a, tx_ready_a}, 0);
    check("rst_busy", busy_a, 0);
    check("rst_grant", grant_a, 0);
    check("rst_cnt", {cnt2_a, cnt4_a, cnt6_a}, 0);

    // ---------------- EP2 three-word burst ----------------
    apply_reset();
    flaga = 1'b1; rx2_ready = 1'b1; fd_i = 16'h1111;
    tick(3);   // cycle 1: ADDR
    check("rd_addr_busy", busy_a, 1);
    check("rd_addr_grant", grant_a, 1);
    check("rd_addr_sloe", sloe_a, 0);
    check("rd_addr_slrd", slrd_a, 1);
    check("rd_addr_fifoaddr", fifoaddr_a, 2'b00);
    tick(2);   // cycle 3
    check("rd_slrd_c3", slrd_a, 0);
    tick(3);   // cycle 6
    check("rd_slrd_c6", slrd_a, 0);
    tick(1);   // cycle 7
    check("rd_slrd_c7", slrd_a, 1);
    check("rd_valid_w1", rx2_valid_a, 1);
    check("rd_data_w1", rx_data_a, 16'h1111);
    check("rd_cnt_w1", cnt2_a, 1);
    fd_i = 16'h2222;
    tick(1);   // cycle 8
    check("rd_valid_pulse", rx2_valid_a, 0);
    check("rd_sloe_held", sloe_a, 0);
    tick(3);   // cycle 11: next in-burst strobe
    check("rd_slrd_c11", slrd_a, 0);
    tick(4);   // cycle 15
    check("rd_valid_w2", rx2_valid_a, 1);
    check("rd_data_w2", rx_data_a, 16'h2222);
    fd_i = 16'h3333;
    tick(8);   // cycle 23
    check("rd_valid_w3", rx2_valid_a, 1);
    check("rd_data_w3", rx_data_a, 16'h3333);
    check("rd_cnt_w3", cnt2_a, 3);
    flaga = 1'b0;
    tick(4);   // cycle 27
    check("rd_end_busy", busy_a, 0);
    check("rd_end_grant", grant_a, 0);
    check("rd_end_sloe", sloe_a, 1);
    tick(12);
    check("rd_end_cnt", cnt2_a, 3);

    // ---------------- EP6 write, flagc drops in word 2 ----------------
    apply_reset();
    flagc = 1'b1; tx_valid = 1'b1; tx_data = 16'hA5A5;
    tick(3);   // cycle 1: TURN
    check("wr_turn_grant", grant_a, 3);
    check("wr_turn_oe", fd_oe_a, 0);
    check("wr_turn_sloe", sloe_a, 1);
    tick(2);   // cycle 3: ADDR
    check("wr_addr_oe", fd_oe_a, 1);
    check("wr_addr_fd_o", fd_o_a, 16'hA5A5);
    check("wr_addr_fifoaddr", fifoaddr_a, 2'b10);
    check("wr_addr_slwr", slwr_a, 1);
    tick(2);   // cycle 5
    check("wr_slwr_c5", slwr_a, 0);
    tick(4);   // cycle 9
    check("wr_ready_w1", tx_ready_a, 1);
    check("wr_cnt_w1", cnt6_a, 1);
    tick(4);   // cycle 13
    check("wr_slwr_c13", slwr_a, 0);
    tick(1);   // cycle 14
    flagc = 1'b0;
    tick(2);   // cycle 16
    check("wr_no_abort", slwr_a, 0);
    tick(1);   // cycle 17
    check("wr_ready_w2", tx_ready_a, 1);
    check("wr_cnt_w2", cnt6_a, 2);
    tick(4);   // cycle 21
    check("wr_idle_busy", busy_a, 0);
    check("wr_idle_oe", fd_oe_a, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (!slwr_a) bad++;
    end
    check("wr_no_third", bad, 0);

    // ---------------- reset during read strobe ----------------
    apply_reset();
    flaga = 1'b1; rx2_ready = 1'b1; fd_i = 16'hBEEF;
    tick(6);   // cycle 4
    check("rr_pre_slrd", slrd_a, 0);
    #1 reset_n = 1'b0;
    #1;
    check("rr_slrd", slrd_a, 1);
    check("rr_sloe", sloe_a, 1);
    check("rr_fd_oe", fd_oe_a, 0);
    check("rr_busy", busy_a, 0);
    check("rr_cnt", cnt2_a, 0);
    tick(1);
    reset_n = 1'b1;
    tick(9);   // cycle 7 of the restarted word
    check("rr_restart_valid", rx2_valid_a, 1);
    check("rr_restart_data", rx_data_a, 16'hBEEF);
    check("rr_restart_cnt", cnt2_a, 1);

    // ---------------- round robin, BURST_MAX=2 (instance B) ----------------
    apply_reset();
    flaga = 1'b1; flagb = 1'b1; flagc = 1'b1;
    rx2_ready = 1'b1; rx4_ready = 1'b1; tx_valid = 1'b1; tx_data = 16'h5A5A;
    nwords = 0; ngaps = 0; gap = 0; viol = 0; gap_run = 1'b0; prev_g = 2'd0;
    for (int i = 0; i < 400 && nwords < 8; i++) begin
      tick(1);
      if (grant_b != 2'd0 && prev_g == 2'd0) begin
        gap_run = 1'b1;
        gap = 0;
      end
      if (gap_run) begin
        if (!slrd_b || !slwr_b) begin
          if (ngaps < 4) obs_gaps[ngaps] = gap;
          ngaps++;
          gap_run = 1'b0;
        end else gap++;
      end
      if (rx2_valid_b || rx4_valid_b || tx_ready_b) begin
        obs_words[nwords] = grant_b;
        nwords++;
      end
      if ((fd_oe_b && !sloe_b) || (fd_oe_a && !sloe_a)) viol++;
      prev_g = grant_b;
    end
    check("rr_word_count", nwords, 8);
    for (int i = 0; i < 8; i++) check($sformatf("rr_word%0d", i), obs_words[i], exp_words[i]);
    for (int i = 0; i < 4; i++) check($sformatf("rr_gap%0d", i), obs_gaps[i], exp_gaps[i]);
    check("rr_oe_sloe_overlap", viol, 0);

    // ---------------- cnt6 wrap, CNT_W=4 (instance B) ----------------
    apply_reset();
    flagc = 1'b1; tx_valid = 1'b1; tx_data = 16'h0F0F;
    pulses = 0;
    for (int i = 0; i < 1000 && pulses < 16; i++) begin
      tick(1);
      if (tx_ready_b) begin
        pulses++;
        if (pulses == 15) check("wrap_cnt15", cnt6_b, 4'd15);
        if (pulses == 16) check("wrap_cnt0", cnt6_b, 4'd0);
      end
    end
    check("wrap_pulses", pulses, 16);

    // ---------------- en low holds off all grants ----------------
    apply_reset();
    en = 1'b0;
    flaga = 1'b1; flagb = 1'b1; flagc = 1'b1;
    rx2_ready = 1'b1; rx4_ready = 1'b1; tx_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (!slrd_a || !slwr_a || busy_a || !slrd_b || !slwr_b) bad++;
    end
    check("en_low_quiet", bad, 0);
    en = 1'b1;
    tick(1);
    check("en_grant_a", grant_a, 1);
    check("en_busy_a", busy_a, 1);
    check("en_grant_b", grant_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
